menu_text_buf: RTL and testbench

Writable, parametrised character buffer for the menu text overlay, the successor to the fixed per-screen text ROMs. It holds a `COLS` x `ROWS` grid of character codes addressed as `{row, col}`. The grid is filled at run time through a cursor-based write port with auto-advance, newline and wrap-around. A registered read port feeds the font ROM / `char_code` path, and a built-in clear engine blanks the grid after reset or on request.

---
 rtl/menu_text_buf.sv | 76 +++++++
 tb/tb_menu_text_buf.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/menu_text_buf.sv
// menu_text_buf: cursor-addressed character grid with auto-clear engine and registered read port
module menu_text_buf #(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CODE_W = 7,
  parameter logic [CODE_W-1:0] FILL_CODE = '0,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int XY_W = RW + CW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XY_W-1:0]   char_xy,
  output logic [CODE_W-1:0] char_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_nl,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              cur_set,
  input  logic [XY_W-1:0]   cur_xy,
  input  logic              clr_start,
  output logic              busy,
  output logic [XY_W-1:0]   cursor_xy
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nxt;
  logic [XY_W-1:0] clr_addr, clr_nxt, cur_nxt, wa;
  logic [CODE_W-1:0] wd;
  logic we;
  logic [CODE_W-1:0] mem [ROWS*COLS];
  assign busy = state == CLEAR;
  assign wr_ready = state == IDLE && !cur_set && !clr_start;
  // {row, col} with power-of-two sizes: +1 carries col into row and wraps the grid
  always_comb begin
    state_nxt = state;
    clr_nxt = clr_addr;
    cur_nxt = cursor_xy;
    we = 1'b0;
    wa = clr_addr;
    wd = FILL_CODE;
    if (busy) begin
      we = 1'b1;
      clr_nxt = clr_addr + 1'b1;
      if (&clr_addr) begin
        state_nxt = IDLE;
        cur_nxt = '0;
      end
    end else if (clr_start) begin
      state_nxt = CLEAR;
      clr_nxt = '0;
    end else if (cur_set) begin
      cur_nxt = cur_xy;
    end else if (wr_valid) begin
      we = !wr_nl;
      wa = cursor_xy;
      wd = wr_code;
      cur_nxt = wr_nl ? {cursor_xy[XY_W-1:CW] + 1'b1, {CW{1'b0}}} : cursor_xy + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_addr <= '0;
      cursor_xy <= '0;
      char_code <= '0;
    end else begin
      state <= state_nxt;
      clr_addr <= clr_nxt;
      cursor_xy <= cur_nxt;
      char_code <= mem[char_xy];
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
endmodule

// File: tb/tb_menu_text_buf.sv
// tb_menu_text_buf: directed vector table plus clear/reset sequences for menu_text_buf
module tb_menu_text_buf;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] char_xy = '0, cur_xy = '0, cursor_xy;
  logic [6:0] char_code, wr_code = '0;
  logic wr_valid = 1'b0, wr_ready, wr_nl = 1'b0, cur_set = 1'b0, clr_start = 1'b0, busy;
  int checks = 0, errors = 0;

  menu_text_buf dut (
    .clk(clk), .rst_n(rst_n), .char_xy(char_xy), .char_code(char_code),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_nl(wr_nl), .wr_code(wr_code),
    .cur_set(cur_set), .cur_xy(cur_xy), .clr_start(clr_start), .busy(busy),
    .cursor_xy(cursor_xy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic wv, nl;
    logic [6:0] code;
    logic cs;
    logic [7:0] cxy, rxy;
    logic rdy;
    logic [7:0] ecur;
    logic chk;
    logic [6:0] ecode;
  } vec_t;
  vec_t vec [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [6:0] exp);
    @(negedge clk);
    char_xy = a;
    @(posedge clk);
    #1 chk($sformatf("read %0h", a), char_code, exp);
  endtask

  // entered #1 after a negedge; counts cycles with busy high before each edge
  task automatic wait_clear(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    for (int k = 0; k < 1000; k++) begin
      if (!busy) break;
      n++;
      if (wr_ready) rdy_hi++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, rh;
    vec[0]  = '{1'b1, 1'b0, 7'h4D, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 7'h00};
    vec[1]  = '{1'b1, 1'b0, 7'h41, 1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 1'b1, 7'h4D};
    vec[2]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'h02, 1'b1, 7'h41};
    vec[3]  = '{1'b1, 1'b0, 7'h11, 1'b1, 8'h2F, 8'h02, 1'b0, 8'h2F, 1'b1, 7'h00};
    vec[4]  = '{1'b1, 1'b0, 7'h54, 1'b0, 8'h00, 8'h02, 1'b1, 8'h30, 1'b1, 7'h00};
    vec[5]  = '{1'b1, 1'b0, 7'h45, 1'b0, 8'h00, 8'h2F, 1'b1, 8'h31, 1'b1, 7'h54};
    vec[6]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h30, 1'b1, 8'h31, 1'b1, 7'h45};
    vec[7]  = '{1'b0, 1'b0, 7'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 7'h00};
    vec[8]  = '{1'b1, 1'b0, 7'h5A, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 7'h00};
    vec[9]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 7'h5A};
    vec[10] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'h23, 8'h00, 1'b0, 8'h23, 1'b0, 7'h00};
    vec[11] = '{1'b1, 1'b1, 7'h77, 1'b0, 8'h00, 8'h23, 1'b1, 8'h30, 1'b1, 7'h00};
    vec[12] = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h23, 1'b1, 8'h30, 1'b1, 7'h00};
    vec[13] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 7'h00};
    vec[14] = '{1'b1, 1'b0, 7'h33, 1'b0, 8'h00, 8'h05, 1'b1, 8'h06, 1'b1, 7'h00};
    vec[15] = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h05, 1'b1, 8'h06, 1'b1, 7'h33};
    vec[16] = '{1'b1, 1'b1, 7'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0, 7'h00};
    vec[17] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'hF4, 8'h00, 1'b0, 8'hF4, 1'b0, 7'h00};
    vec[18] = '{1'b1, 1'b1, 7'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 7'h00};

    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", busy, 1);
    chk("reset wr_ready", wr_ready, 0);
    chk("reset cursor", cursor_xy, 0);
    chk("reset char_code", char_code, 0);
    rst_n = 1'b1;
    wait_clear(n, rh);
    chk("init busy cycles", n, 256);
    chk("init wr_ready during clear", rh, 0);
    chk("init cursor", cursor_xy, 0);
    rd(8'h00, 7'h00);
    rd(8'h7F, 7'h00);
    rd(8'hFF, 7'h00);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      wr_valid = vec[i].wv;
      wr_nl = vec[i].nl;
      wr_code = vec[i].code;
      cur_set = vec[i].cs;
      cur_xy = vec[i].cxy;
      char_xy = vec[i].rxy;
      #1 chk($sformatf("v%0d wr_ready", i), wr_ready, vec[i].rdy);
      @(posedge clk);
      #1 chk($sformatf("v%0d cursor", i), cursor_xy, vec[i].ecur);
      if (vec[i].chk) chk($sformatf("v%0d char_code", i), char_code, vec[i].ecode);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_nl = 1'b0;
    cur_set = 1'b1;
    cur_xy = 8'h44;
    @(negedge clk);
    cur_set = 1'b0;
    clr_start = 1'b1;
    wr_valid = 1'b1;
    wr_code = 7'h66;
    #1 chk("clr_start wr_ready", wr_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    #1 wait_clear(n, rh);
    wr_valid = 1'b0;
    chk("clear busy cycles", n, 256);
    chk("clear wr_ready low cycles", 1 + n - rh, 257);
    chk("clear cursor", cursor_xy, 0);
    rd(8'h00, 7'h00);
    rd(8'h01, 7'h00);
    rd(8'h2F, 7'h00);
    rd(8'h30, 7'h00);
    rd(8'hFF, 7'h00);
    rd(8'h05, 7'h00);

    @(negedge clk);
    cur_set = 1'b1;
    cur_xy = 8'h44;
    @(negedge clk);
    cur_set = 1'b0;
    clr_start = 1'b1;
    @(posedge clk);
    #1 clr_start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midclear reset busy", busy, 1);
    chk("midclear reset cursor", cursor_xy, 0);
    chk("midclear reset wr_ready", wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 wait_clear(n, rh);
    chk("restart busy cycles", n, 256);
    chk("restart cursor", cursor_xy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
